// File: rtl/autofire_multi_if.sv
// Autofire control bundle: shared timebase, per-channel speed/trigger edges in, masks and speeds out.
// master drives the controls, slave (the autofire block) returns mask and speed.
interface autofire_multi_if #(
    parameter int CHANNELS   = 2,
    parameter int SPEED_BITS = 4
);
    logic                           count_en;
    logic [CHANNELS-1:0]            af_increment;
    logic [CHANNELS-1:0]            af_decriment;
    logic [CHANNELS-1:0]            af_trig;
    logic [CHANNELS-1:0]            af_mask;
    logic [CHANNELS*SPEED_BITS-1:0] af_speed;

    modport master (
        output count_en, af_increment, af_decriment, af_trig,
        input  af_mask, af_speed
    );

    modport slave (
        input  count_en, af_increment, af_decriment, af_trig,
        output af_mask, af_speed
    );
endinterface

// File: rtl/autofire_multi.sv
// Multi-channel autofire: per-channel saturating speed and square-wave fire mask, trigger restarts phase.
// Latency 1 clk from first sampled rising edge to mask/speed; no backpressure, inputs are level lines sampled every clk.
module autofire_multi #(
    parameter int CHANNELS      = 2,
    parameter int SPEED_BITS    = 4,
    parameter int DEFAULT_SPEED = 0
) (
    input  logic              clk21m,
    input  logic              reset_n,
    autofire_multi_if.slave   af
);
    localparam int                    CNT_BITS  = SPEED_BITS + 1;
    localparam logic [SPEED_BITS-1:0] SPEED_MAX = '1;
    localparam logic [SPEED_BITS-1:0] SPEED_RST = SPEED_BITS'(DEFAULT_SPEED);
    localparam logic [CNT_BITS-1:0]   FULL      = CNT_BITS'(2 ** SPEED_BITS);

    // Half-period in ticks: MAX -> 1, 1 -> MAX.
    function automatic logic [CNT_BITS-1:0] half(input logic [SPEED_BITS-1:0] s);
        return FULL - {1'b0, s};
    endfunction

    logic                  count_en_q;
    logic [CHANNELS-1:0]   inc_q, dec_q, trig_q;
    logic                  edge_arm;
    logic                  tick;
    logic [CHANNELS-1:0]   inc_rise, dec_rise, trig_rise;

    logic [SPEED_BITS-1:0] speed_q   [CHANNELS];
    logic [SPEED_BITS-1:0] speed_nxt [CHANNELS];
    logic [CNT_BITS-1:0]   cnt_q     [CHANNELS];
    logic [CHANNELS-1:0]   mask_q;

    // edge_arm masks the first cycle after reset release, so a line already high then is not an edge.
    assign tick      = af.count_en & ~count_en_q & edge_arm;
    assign inc_rise  = af.af_increment & ~inc_q  & {CHANNELS{edge_arm}};
    assign dec_rise  = af.af_decriment & ~dec_q  & {CHANNELS{edge_arm}};
    assign trig_rise = af.af_trig      & ~trig_q & {CHANNELS{edge_arm}};

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            count_en_q <= 1'b0;
            inc_q      <= '0;
            dec_q      <= '0;
            trig_q     <= '0;
            edge_arm   <= 1'b0;
        end else begin
            count_en_q <= af.count_en;
            inc_q      <= af.af_increment;
            dec_q      <= af.af_decriment;
            trig_q     <= af.af_trig;
            edge_arm   <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            speed_nxt[i] = speed_q[i];
            if (inc_rise[i] && !dec_rise[i] && speed_q[i] != SPEED_MAX)
                speed_nxt[i] = speed_q[i] + SPEED_BITS'(1);
            else if (dec_rise[i] && !inc_rise[i] && speed_q[i] != '0)
                speed_nxt[i] = speed_q[i] - SPEED_BITS'(1);
        end
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                speed_q[i] <= SPEED_RST;
                cnt_q[i]   <= half(SPEED_RST);
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (speed_nxt[i] != speed_q[i]) begin
                    speed_q[i] <= speed_nxt[i];
                    mask_q[i]  <= 1'b1;
                    cnt_q[i]   <= (speed_nxt[i] == '0) ? '0 : half(speed_nxt[i]);
                end else if (speed_q[i] == '0) begin
                    mask_q[i] <= 1'b1;
                    cnt_q[i]  <= '0;
                end else if (trig_rise[i]) begin
                    // Restart the phase; a coincident tick is dropped.
                    mask_q[i] <= 1'b1;
                    cnt_q[i]  <= half(speed_q[i]);
                end else if (tick) begin
                    if (cnt_q[i] <= CNT_BITS'(1)) begin
                        mask_q[i] <= ~mask_q[i];
                        cnt_q[i]  <= half(speed_q[i]);
                    end else begin
                        cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
                    end
                end
            end
        end
    end

    assign af.af_mask = mask_q;

    always_comb begin
        af.af_speed = '0;
        for (int i = 0; i < CHANNELS; i++)
            af.af_speed[i*SPEED_BITS +: SPEED_BITS] = speed_q[i];
    end
endmodule
